// File: rtl/stage4_mem_access.sv
// Memory-access stage of the 5-stage MIPS core.
// Holds the shared data/call-stack memory, resolves PC redirects for
// branch/jump/call/return, exposes unregistered forwarding copies of the
// ALU result and load data, and registers the MEM/WB fields.
module stage4_mem_access #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BR_Ex,
  input  logic        JMP_flag,
  input  logic [15:0] imm,
  input  logic        CALL_flag,
  input  logic        RET_flag,
  input  logic        Memory_Read,
  input  logic        Memory_Write,
  input  logic [31:0] Result,
  input  logic [11:0] SP_Data,
  input  logic [31:0] data1,
  input  logic [4:0]  Addr_Write_Reg_in,
  input  logic        Reg_Write_En_in,
  input  logic        WB_Mux_sel_in,
  output logic        BR_JMP_Ex,
  output logic [11:0] next_PC,
  output logic [31:0] Mem_out_no_Pipeline,
  output logic [31:0] ALU_out_no_Pipeline,
  output logic [31:0] Result_out,
  output logic [4:0]  Addr_Write_Reg_out,
  output logic [31:0] Memory_Data,
  output logic        Reg_Write_En_out,
  output logic        WB_Mux_sel_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Data and stack share one array; stack frames live wherever SP points.
  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] data_addr;
  logic [DEPTH_LOG2-1:0] sp_addr;
  logic [31:0]           sp_word;
  logic [31:0]           rd;

  // Only the low 12 bits of imm form a PC target.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[15:12];

  // Upper address bits are dropped, so accesses wrap around the array.
  assign data_addr = Result[DEPTH_LOG2-1:0];
  assign sp_addr   = SP_Data[DEPTH_LOG2-1:0];
  assign sp_word   = mem[sp_addr];

  // Write port: a CALL pushes the return address and wins over a store;
  // nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CALL_flag) begin
        mem[sp_addr] <= data1;
      end else if (Memory_Write) begin
        mem[data_addr] <= data1;
      end
    end
  end

  // Asynchronous read: a return pops from the stack slot, else a load.
  // Same-cycle write-then-read sees the old word since writes land at the edge.
  always_comb begin
    rd = 32'd0;
    if (RET_flag) begin
      rd = sp_word;
    end else if (Memory_Read) begin
      rd = mem[data_addr];
    end
  end

  assign Mem_out_no_Pipeline = rd;
  assign ALU_out_no_Pipeline = Result;

  // Redirect resolution, RET > CALL > JMP > BR.
  always_comb begin
    BR_JMP_Ex = 1'b0;
    next_PC   = 12'd0;
    if (RET_flag) begin
      BR_JMP_Ex = 1'b1;
      next_PC   = sp_word[11:0];
    end else if (CALL_flag || JMP_flag || BR_Ex) begin
      BR_JMP_Ex = 1'b1;
      next_PC   = imm[11:0];
    end
  end

  logic [31:0] result_q,  result_d;
  logic [4:0]  awr_q,     awr_d;
  logic [31:0] mdata_q,   mdata_d;
  logic        rwe_q,     rwe_d;
  logic        wbsel_q,   wbsel_d;

  // Next-state for the MEM/WB register: a plain capture every cycle.
  always_comb begin
    result_d = Result;
    awr_d    = Addr_Write_Reg_in;
    mdata_d  = rd;
    rwe_d    = Reg_Write_En_in;
    wbsel_d  = WB_Mux_sel_in;
  end

  // MEM/WB pipeline register; reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= 32'd0;
      awr_q    <= 5'd0;
      mdata_q  <= 32'd0;
      rwe_q    <= 1'b0;
      wbsel_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      awr_q    <= awr_d;
      mdata_q  <= mdata_d;
      rwe_q    <= rwe_d;
      wbsel_q  <= wbsel_d;
    end
  end

  assign Result_out         = result_q;
  assign Addr_Write_Reg_out = awr_q;
  assign Memory_Data        = mdata_q;
  assign Reg_Write_En_out   = rwe_q;
  assign WB_Mux_sel_out     = wbsel_q;

endmodule

// File: tb/tb_stage4_mem_access.sv
// Scoreboard bench for stage4_mem_access: directed scenarios followed by
// randomized traffic, checked against a word-array reference model.
module tb_stage4_mem_access;

  logic        clk;
  logic        reset;
  logic        BR_Ex, JMP_flag, CALL_flag, RET_flag;
  logic [15:0] imm;
  logic        Memory_Read, Memory_Write;
  logic [31:0] Result;
  logic [11:0] SP_Data;
  logic [31:0] data1;
  logic [4:0]  Addr_Write_Reg_in;
  logic        Reg_Write_En_in, WB_Mux_sel_in;
  logic        BR_JMP_Ex;
  logic [11:0] next_PC;
  logic [31:0] Mem_out_no_Pipeline, ALU_out_no_Pipeline, Result_out, Memory_Data;
  logic [4:0]  Addr_Write_Reg_out;
  logic        Reg_Write_En_out, WB_Mux_sel_out;

  stage4_mem_access #(.DEPTH_LOG2(12)) dut (
    .clk(clk), .reset(reset), .BR_Ex(BR_Ex), .JMP_flag(JMP_flag), .imm(imm),
    .CALL_flag(CALL_flag), .RET_flag(RET_flag), .Memory_Read(Memory_Read),
    .Memory_Write(Memory_Write), .Result(Result), .SP_Data(SP_Data), .data1(data1),
    .Addr_Write_Reg_in(Addr_Write_Reg_in), .Reg_Write_En_in(Reg_Write_En_in),
    .WB_Mux_sel_in(WB_Mux_sel_in), .BR_JMP_Ex(BR_JMP_Ex), .next_PC(next_PC),
    .Mem_out_no_Pipeline(Mem_out_no_Pipeline), .ALU_out_no_Pipeline(ALU_out_no_Pipeline),
    .Result_out(Result_out), .Addr_Write_Reg_out(Addr_Write_Reg_out),
    .Memory_Data(Memory_Data), .Reg_Write_En_out(Reg_Write_En_out),
    .WB_Mux_sel_out(WB_Mux_sel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        br;
    bit [11:0] npc;
    bit        npc_known;
    bit [31:0] mem_out;
    bit        mem_known;
    bit [31:0] alu;
    bit        reg_known;
    bit [31:0] res_o;
    bit [4:0]  awr_o;
    bit [31:0] md;
    bit        md_known;
    bit        rwe_o;
    bit        wbs_o;
  } exp_t;

  exp_t scb[$];

  // Reference model: a plain word array plus a "has been written" map.
  bit [31:0] mmem [4096];
  bit        mval [4096];
  exp_t      prev;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      chk("BR_JMP_Ex", {31'd0, BR_JMP_Ex}, {31'd0, e.br});
      if (e.npc_known) chk("next_PC", {20'd0, next_PC}, {20'd0, e.npc});
      if (e.mem_known) chk("Mem_out_no_Pipeline", Mem_out_no_Pipeline, e.mem_out);
      chk("ALU_out_no_Pipeline", ALU_out_no_Pipeline, e.alu);
      if (e.reg_known) begin
        chk("Result_out", Result_out, e.res_o);
        chk("Addr_Write_Reg_out", {27'd0, Addr_Write_Reg_out}, {27'd0, e.awr_o});
        chk("Reg_Write_En_out", {31'd0, Reg_Write_En_out}, {31'd0, e.rwe_o});
        chk("WB_Mux_sel_out", {31'd0, WB_Mux_sel_out}, {31'd0, e.wbs_o});
        if (e.md_known) chk("Memory_Data", Memory_Data, e.md);
      end
    end
  end

  // One cycle: predict this cycle's outputs, then advance the model at the edge.
  task automatic step();
    exp_t      e;
    bit [31:0] rdv;
    bit        rdk;
    int        da, sa;
    da = int'(Result[11:0]);
    sa = int'(SP_Data);
    if (RET_flag) begin
      rdv = mmem[sa]; rdk = mval[sa];
    end else if (Memory_Read) begin
      rdv = mmem[da]; rdk = mval[da];
    end else begin
      rdv = 32'd0; rdk = 1'b1;
    end
    e = prev;
    e.mem_out   = rdv;
    e.mem_known = rdk;
    e.alu       = Result;
    if (RET_flag) begin
      e.br = 1'b1; e.npc = rdv[11:0]; e.npc_known = rdk;
    end else if (CALL_flag || JMP_flag || BR_Ex) begin
      e.br = 1'b1; e.npc = imm[11:0]; e.npc_known = 1'b1;
    end else begin
      e.br = 1'b0; e.npc = 12'd0; e.npc_known = 1'b1;
    end
    scb.push_back(e);
    @(posedge clk);
    if (reset) begin
      if (CALL_flag) begin
        mmem[sa] = data1; mval[sa] = 1'b1;
      end else if (Memory_Write) begin
        mmem[da] = data1; mval[da] = 1'b1;
      end
      prev.reg_known = 1'b1;
      prev.res_o = Result;  prev.awr_o = Addr_Write_Reg_in;
      prev.md = rdv;        prev.md_known = rdk;
      prev.rwe_o = Reg_Write_En_in; prev.wbs_o = WB_Mux_sel_in;
    end else begin
      prev.reg_known = 1'b1;
      prev.res_o = 32'd0; prev.awr_o = 5'd0; prev.md = 32'd0; prev.md_known = 1'b1;
      prev.rwe_o = 1'b0;  prev.wbs_o = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; BR_Ex = 1'b0; JMP_flag = 1'b0; CALL_flag = 1'b0; RET_flag = 1'b0;
    Memory_Read = 1'b0; Memory_Write = 1'b0; imm = 16'd0; Result = 32'd0;
    SP_Data = 12'd0; data1 = 32'd0; Addr_Write_Reg_in = 5'd0;
    Reg_Write_En_in = 1'b0; WB_Mux_sel_in = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle(); Memory_Write = 1'b1; Result = a; data1 = d; step();
  endtask

  task automatic load(input logic [31:0] a);
    idle(); Memory_Read = 1'b1; Result = a; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waddr [5] = '{8, 9, 10, 57, 58};
    int wdata [5] = '{37, 39, 43, 55, 1};
    prev = '{default: '0};
    prev.reg_known = 1'b0;
    idle();
    // Reset held with busy-looking inputs: registers must clear, no write lands.
    reset = 1'b0; Memory_Write = 1'b1; Result = 32'hFFFF_0005; data1 = 32'hDEAD_BEEF;
    Addr_Write_Reg_in = 5'd9; Reg_Write_En_in = 1'b1; WB_Mux_sel_in = 1'b1; Memory_Read = 1'b1;
    @(posedge clk); #1;
    step();
    step();

    for (int i = 0; i < 5; i++) store(32'(waddr[i]), 32'(wdata[i]));
    for (int i = 0; i < 5; i++) load(32'(waddr[i]));
    load(32'hABCD_0008);  // upper address bits wrap onto word 8

    idle(); Result = 32'h1234; Addr_Write_Reg_in = 5'd17; Reg_Write_En_in = 1'b1;
    WB_Mux_sel_in = 1'b1; step();

    idle(); CALL_flag = 1'b1; SP_Data = 12'd100; data1 = 32'h05A; imm = 16'h0300; step();
    idle(); RET_flag = 1'b1; SP_Data = 12'd100; step();

    idle(); JMP_flag = 1'b1; BR_Ex = 1'b1; imm = 16'hF0AB; step();
    idle(); BR_Ex = 1'b1; imm = 16'h0123; step();
    idle(); RET_flag = 1'b1; CALL_flag = 1'b1; SP_Data = 12'd100; imm = 16'h0777;
    data1 = 32'h0000_0BCD; step();
    idle(); RET_flag = 1'b1; SP_Data = 12'd100; step();
    idle(); step();

    store(32'd20, 32'd7);
    idle(); Memory_Write = 1'b1; Memory_Read = 1'b1; Result = 32'd20; data1 = 32'd9; step();
    load(32'd20);

    // Reset mid-operation suppresses the write and drops in-flight values.
    store(32'd5, 32'h0000_AAAA);
    idle(); Result = 32'h55; Reg_Write_En_in = 1'b1; Addr_Write_Reg_in = 5'd3; step();
    idle(); reset = 1'b0; Memory_Write = 1'b1; Result = 32'd5; data1 = 32'h0000_BBBB; step();
    idle(); reset = 1'b0; CALL_flag = 1'b1; SP_Data = 12'd5; data1 = 32'h0000_CCCC; step();
    load(32'd5);
    idle(); step();

    for (int i = 0; i < 400; i++) begin
      reset             = ($urandom_range(0, 19) != 0);
      RET_flag          = ($urandom_range(0, 7) == 0);
      CALL_flag         = ($urandom_range(0, 7) == 0);
      JMP_flag          = ($urandom_range(0, 5) == 0);
      BR_Ex             = ($urandom_range(0, 5) == 0);
      Memory_Read       = 1'($urandom_range(0, 1));
      Memory_Write      = ($urandom_range(0, 2) == 0);
      Result            = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      SP_Data           = 12'(4080 + $urandom_range(0, 15));
      data1             = $urandom();
      imm               = 16'($urandom());
      Addr_Write_Reg_in = 5'($urandom());
      Reg_Write_En_in   = 1'($urandom_range(0, 1));
      WB_Mux_sel_in     = 1'($urandom_range(0, 1));
      step();
    end

    idle();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4_mem_access.md
Name: stage4_mem_access

Overview:
Memory-access stage (pipeline stage 4) of the 5-stage MIPS core. It holds the data memory and the call stack storage, and resolves branch/jump/call/return targets into next_PC. It provides unregistered forwarding copies of the ALU result and memory read data, and registers the MEM/WB pipeline fields for write-back.

Parameters:
DEPTH_LOG2, 12, data-memory address width; depth = 2**DEPTH_LOG2 words of 32 bits.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (asserted when 0)
BR_Ex  in  1  branch taken, resolved in execute
JMP_flag  in  1  unconditional jump
imm  in  16  target address; imm[11:0] is used
CALL_flag  in  1  call: push return address, jump to imm
RET_flag  in  1  return: pop target from stack
Memory_Read  in  1  load enable
Memory_Write  in  1  store enable
Result  in  32  ALU result / memory address
SP_Data  in  12  current stack pointer (stack slot address)
data1  in  32  store data; return address on CALL
Addr_Write_Reg_in  in  5  destination register
Reg_Write_En_in  in  1  register write enable
WB_Mux_sel_in  in  1  write-back select (1 = memory data)
BR_JMP_Ex  out  1  PC redirect request
next_PC  out  12  redirect target
Mem_out_no_Pipeline  out  32  combinational load data (forwarding)
ALU_out_no_Pipeline  out  32  combinational copy of Result (forwarding)
Result_out  out  32  registered Result
Addr_Write_Reg_out  out  5  registered destination register
Memory_Data  out  32  registered load data
Reg_Write_En_out  out  1  registered write enable
WB_Mux_sel_out  out  1  registered write-back select

Behaviour:
- Memory: DEPTH words x 32, single array shared by data and stack. Asynchronous read, synchronous write on the clk rising edge. Contents are not cleared by reset; initial contents are don't-care.
- Address: data address = Result[DEPTH_LOG2-1:0]; upper bits are ignored (wrap-around). Stack address = SP_Data[DEPTH_LOG2-1:0].
- Write port:
  - If CALL_flag=1: mem[SP] <= data1.
  - Else if Memory_Write=1: mem[Result] <= data1.
  - No write occurs while reset=0.
- Read:
  - If RET_flag=1: rd = mem[SP].
  - Else if Memory_Read=1: rd = mem[Result].
  - Else rd = 0.
  - A read in the same cycle as a write to the same address returns the old contents.
- Mem_out_no_Pipeline = rd (combinational). ALU_out_no_Pipeline = Result (combinational).
- Redirect (combinational), priority RET > CALL > JMP > BR:
  - RET: BR_JMP_Ex=1, next_PC = mem[SP][11:0].
  - CALL, JMP_flag or BR_Ex: BR_JMP_Ex=1, next_PC = imm[11:0].
  - None active: BR_JMP_Ex=0, next_PC=0.
- Pipeline registers, updated on every rising edge:
  - Result_out <= Result
  - Addr_Write_Reg_out <= Addr_Write_Reg_in
  - Memory_Data <= rd
  - Reg_Write_En_out <= Reg_Write_En_in
  - WB_Mux_sel_out <= WB_Mux_sel_in
  - Latency: 1 cycle.
- Reset (reset=0 at a rising edge): all registered outputs become 0. Combinational outputs continue to follow their inputs. Reset asserted mid-operation drops in-flight register values and suppresses that cycle's write. No stall or flush inputs exist.

Test Plan:
- Reset: hold reset=0 for 1 cycle with nonzero inputs -> all registered outputs 0, no memory write.
- Store/load: write (Result,data1) = (8,37), (9,39), (10,43), (57,55), (58,1), one per cycle with Memory_Write=1. Then read addresses 8, 9, 10, 57, 58 with Memory_Read=1 -> Mem_out_no_Pipeline = 37, 39, 43, 55, 1 in the same cycle; Memory_Data shows the same values one cycle later.
- Pipeline passthrough: Result=0x1234, Addr_Write_Reg_in=5'd17, Reg_Write_En_in=1, WB_Mux_sel_in=1 -> the _out registers hold these values after one edge; ALU_out_no_Pipeline = 0x1234 immediately.
- CALL then RET: SP_Data=100, data1=0x05A, imm=0x300, CALL_flag=1 -> BR_JMP_Ex=1, next_PC=0x300, mem[100]=0x05A. Next cycle RET_flag=1, SP_Data=100 -> BR_JMP_Ex=1, next_PC=0x05A.
- Priority: JMP_flag=1 and BR_Ex=1 with imm=0x0AB -> next_PC=0x0AB; RET with CALL -> RET target is used; no flags -> BR_JMP_Ex=0.
- Read-during-write: mem[20]=7, then Memory_Write=1 and Memory_Read=1 on address 20 with data1=9 -> Mem_out_no_Pipeline=7 that cycle, 9 the next cycle.
